// File: rtl/sram_mport_ctrl.sv
// -----------------------------------------------------------------------------
// sram_mport_ctrl
//
// Multi-port controller for an asynchronous single-ported SRAM. NCH requesting
// channels compete for the SRAM through a round-robin arbiter. One request is
// served at a time. Each access holds the SRAM strobes for WAIT+1 cycles. A
// write is followed by one hold cycle, which keeps the address and data stable
// after we_n rises.
//
// Parameters
//   NCH  : number of requesting channels (1..8)
//   AW   : SRAM word-address width
//   DW   : data width, multiple of 8 (BW = DW/8 byte lanes)
//   WAIT : extra access cycles per SRAM access (0..7)
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   req_valid/ready   : per-channel handshake (ready is combinational)
//   req_addr/we/wmask/wdata : flattened per-channel request fields
//   resp_valid        : one-hot, one-cycle completion pulse
//   resp_rdata        : read data, held until the next read completes
//   ram_*             : SRAM pins, all driven straight from flops
// -----------------------------------------------------------------------------
module sram_mport_ctrl #(
  parameter int NCH  = 2,
  parameter int AW   = 20,
  parameter int DW   = 32,
  parameter int WAIT = 1,
  localparam int BW  = DW / 8,
  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH-1:0]    req_we,
  input  logic [NCH*BW-1:0] req_wmask,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]    resp_valid,
  output logic [DW-1:0]     resp_rdata,
  inout  wire  [DW-1:0]     ram_data,
  output logic [AW-1:0]     ram_addr,
  output logic [BW-1:0]     ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    WH   = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;      // channel where the round-robin search starts
  logic [PW-1:0] id_q;     // channel that owns the access in flight
  logic [2:0]    cnt;      // remaining access cycles after the current one
  logic          dq_oe;    // data bus output enable (registered)
  logic [DW-1:0] dq_out;   // registered write data for the bus

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: the first valid channel at or after ptr wins.
  // ---------------------------------------------------------------------------
  logic          grant_found;
  logic [PW-1:0] grant_id;
  logic [PW-1:0] ptr_next;
  int            arb_idx;

  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    arb_idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      arb_idx = (int'(ptr) + k) % NCH;
      if (!grant_found && req_valid[arb_idx]) begin
        grant_found = 1'b1;
        grant_id    = PW'(arb_idx);
      end
    end
  end

  // The pointer moves to the channel after the winner and wraps at NCH.
  always_comb begin
    if (int'(grant_id) == NCH - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_id + PW'(1);
    end
  end

  // A request is offered only in IDLE and only to the winner. Reset masks it,
  // so nothing is accepted while rst is held.
  logic idle_grant;
  assign idle_grant = !rst && (state == IDLE) && grant_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      req_ready[i] = idle_grant && (grant_id == PW'(i));
    end
  end

  // Fields of the winning channel. These are sampled only on acceptance.
  logic [AW-1:0] sel_addr;
  logic [BW-1:0] sel_wmask;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;

  assign sel_addr  = req_addr[int'(grant_id) * AW +: AW];
  assign sel_wmask = req_wmask[int'(grant_id) * BW +: BW];
  assign sel_wdata = req_wdata[int'(grant_id) * DW +: DW];
  assign sel_we    = req_we[grant_id];

  // The bus is driven only from a flop. The enable is set only for WR and WH,
  // so the controller never drives the bus while oe_n is low.
  assign ram_data = dq_oe ? dq_out : {DW{1'bz}};

  // ---------------------------------------------------------------------------
  // Access sequencer. The SRAM pins are computed together with the next state.
  // This way each pin already shows its value in the first cycle of that state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      id_q       <= '0;
      cnt        <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      dq_oe      <= 1'b0;
      dq_out     <= '0;
      ram_addr   <= '0;
      ram_be_n   <= '0;
      ram_ce_n   <= 1'b1;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All flops then
      // update from the same pre-edge values, and the order of statements
      // inside this block does not affect the result.
      resp_valid <= '0;

      unique case (state)
        IDLE: begin
          if (idle_grant) begin
            ptr      <= ptr_next;
            id_q     <= grant_id;
            ram_addr <= sel_addr;
            cnt      <= 3'(WAIT);
            ram_ce_n <= 1'b0;
            if (sel_we) begin
              state    <= WR;
              ram_we_n <= 1'b0;
              ram_oe_n <= 1'b1;
              ram_be_n <= ~sel_wmask;
              dq_out   <= sel_wdata;
              dq_oe    <= 1'b1;
            end else begin
              state    <= RD;
              ram_we_n <= 1'b1;
              ram_oe_n <= 1'b0;
              ram_be_n <= '0;
            end
          end
        end

        RD: begin
          if (cnt == 3'd0) begin
            // Last read cycle: capture the bus and return the pins to idle.
            resp_rdata       <= ram_data;
            resp_valid[id_q] <= 1'b1;
            state            <= IDLE;
            ram_ce_n         <= 1'b1;
            ram_oe_n         <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        WR: begin
          if (cnt == 3'd0) begin
            // we_n rises first. Chip select, address and data stay for one
            // more cycle so the SRAM sees its data hold time.
            state    <= WH;
            ram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        WH: begin
          resp_valid[id_q] <= 1'b1;
          state            <= IDLE;
          ram_ce_n         <= 1'b1;
          ram_be_n         <= '0;
          dq_oe            <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mport_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_mport_ctrl
//
// Two controller instances are built, each attached to a behavioural SRAM:
//   u_a : NCH=2, WAIT=1 -- single-channel transactions driven from a table,
//         reset behaviour, and reset during a write
//   u_b : NCH=3, WAIT=0 -- round-robin order and back-to-back read throughput
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_mport_ctrl;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A: NCH=2, WAIT=1 ----------------
  logic [1:0]      a_req_valid, a_req_ready, a_req_we, a_resp_valid;
  logic [2*AW-1:0] a_req_addr;
  logic [2*BW-1:0] a_req_wmask;
  logic [2*DW-1:0] a_req_wdata;
  logic [DW-1:0]   a_resp_rdata;
  wire  [DW-1:0]   a_ram_data;
  logic [AW-1:0]   a_ram_addr;
  logic [BW-1:0]   a_ram_be_n;
  logic            a_ram_ce_n, a_ram_oe_n, a_ram_we_n;

  sram_mport_ctrl #(.NCH(2), .AW(AW), .DW(DW), .WAIT(1)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_addr(a_req_addr), .req_we(a_req_we),
    .req_wmask(a_req_wmask), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .ram_data(a_ram_data), .ram_addr(a_ram_addr), .ram_be_n(a_ram_be_n),
    .ram_ce_n(a_ram_ce_n), .ram_oe_n(a_ram_oe_n), .ram_we_n(a_ram_we_n)
  );

  // ---------------- instance B: NCH=3, WAIT=0 ----------------
  logic [2:0]      b_req_valid, b_req_ready, b_req_we, b_resp_valid;
  logic [3*AW-1:0] b_req_addr;
  logic [3*BW-1:0] b_req_wmask;
  logic [3*DW-1:0] b_req_wdata;
  logic [DW-1:0]   b_resp_rdata;
  wire  [DW-1:0]   b_ram_data;
  logic [AW-1:0]   b_ram_addr;
  logic [BW-1:0]   b_ram_be_n;
  logic            b_ram_ce_n, b_ram_oe_n, b_ram_we_n;

  sram_mport_ctrl #(.NCH(3), .AW(AW), .DW(DW), .WAIT(0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .req_we(b_req_we),
    .req_wmask(b_req_wmask), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .ram_data(b_ram_data), .ram_addr(b_ram_addr), .ram_be_n(b_ram_be_n),
    .ram_ce_n(b_ram_ce_n), .ram_oe_n(b_ram_oe_n), .ram_we_n(b_ram_we_n)
  );

  // ---------------- behavioural SRAMs (low 8 address bits) ----------------
  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];

  assign a_ram_data = (!a_ram_ce_n && !a_ram_oe_n) ? mem_a[a_ram_addr[7:0]] : {DW{1'bz}};
  assign b_ram_data = (!b_ram_ce_n && !b_ram_oe_n) ? mem_b[b_ram_addr[7:0]] : {DW{1'bz}};

  always @(posedge clk) begin
    if (!a_ram_ce_n && !a_ram_we_n) begin
      for (int b = 0; b < BW; b++) begin
        if (!a_ram_be_n[b]) mem_a[a_ram_addr[7:0]][b*8 +: 8] <= a_ram_data[b*8 +: 8];
      end
    end
    if (!b_ram_ce_n && !b_ram_we_n) begin
      for (int b = 0; b < BW; b++) begin
        if (!b_ram_be_n[b]) mem_b[b_ram_addr[7:0]][b*8 +: 8] <= b_ram_data[b*8 +: 8];
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The SRAM must never see output enable and write strobe low together.
  always @(negedge clk) begin
    if (!rst && !a_ram_oe_n) check("a_oe_with_we", 64'(a_ram_we_n), 64'd1);
    if (!rst && !b_ram_oe_n) check("b_oe_with_we", 64'(b_ram_we_n), 64'd1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table for instance A ----------------
  typedef struct {
    int          ch;
    bit          we;
    logic [19:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    int          exp_lat;    // cycles from acceptance to resp_valid
    logic [31:0] exp_rdata;  // checked for reads only
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // Runs one transaction on instance A. The caller enters #1 after a posedge.
  task automatic a_txn(input int idx, input vec_t v);
    bit          acc;
    bit          found;
    int          cyc;
    int          lat;
    logic [2:0]  exp_pins;
    logic [3:0]  exp_be;
    logic [1:0]  exp_rv;
    a_req_valid = '0;
    a_req_valid[v.ch] = 1'b1;
    a_req_we = '0;
    a_req_we[v.ch] = v.we;
    a_req_addr[v.ch*AW +: AW]  = v.addr;
    a_req_wmask[v.ch*BW +: BW] = v.wmask;
    a_req_wdata[v.ch*DW +: DW] = v.wdata;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 20) begin
      @(negedge clk);
      acc = a_req_ready[v.ch];
      @(posedge clk);
      #1;
      cyc++;
    end
    a_req_valid = '0;
    check($sformatf("v%0d_accept", idx), 64'(acc), 64'd1);
    if (!acc) return;
    lat   = 1;
    found = 1'b0;
    while (!found && lat < 10) begin
      @(negedge clk);
      if (a_resp_valid != '0) begin
        found = 1'b1;
      end else begin
        if (v.we) begin
          exp_pins = (lat <= 2) ? 3'b010 : 3'b011;
          exp_be   = ~v.wmask;
          check($sformatf("v%0d_bus_c%0d", idx, lat), 64'(a_ram_data), 64'(v.wdata));
        end else begin
          exp_pins = 3'b001;
          exp_be   = 4'b0000;
        end
        check($sformatf("v%0d_pins_c%0d", idx, lat),
              64'({a_ram_ce_n, a_ram_oe_n, a_ram_we_n}), 64'(exp_pins));
        check($sformatf("v%0d_be_n_c%0d", idx, lat), 64'(a_ram_be_n), 64'(exp_be));
        @(posedge clk);
        #1;
        lat++;
      end
    end
    exp_rv = 2'b00;
    exp_rv[v.ch] = 1'b1;
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d_resp_valid", idx), 64'(a_resp_valid), 64'(exp_rv));
    check($sformatf("v%0d_idle_pins", idx),
          64'({a_ram_ce_n, a_ram_oe_n, a_ram_we_n}), 64'(3'b111));
    if (!v.we) check($sformatf("v%0d_rdata", idx), 64'(a_resp_rdata), 64'(v.exp_rdata));
    @(posedge clk);
    #1;
  endtask

  // Holds valid on the masked channels of instance B and records n grants.
  // The expected winner of grant i is (i*step)%3. Starting with the second
  // grant, each acceptance must also see the previous read's response.
  task automatic b_stream(input string tag, input logic [2:0] vmask, input int n, input int step);
    int got;
    int cyc;
    int last_cyc;
    int last_ch;
    int ch;
    logic [2:0] exp_rv;
    got      = 0;
    cyc      = 0;
    last_cyc = 0;
    last_ch  = 0;
    b_req_valid = vmask;
    while (got < n && cyc < 60) begin
      @(negedge clk);
      if (b_req_ready != '0) begin
        ch = 0;
        for (int k = 0; k < 3; k++) if (b_req_ready[k]) ch = k;
        check($sformatf("%s_onehot%0d", tag, got), 64'($countones(b_req_ready)), 64'd1);
        check($sformatf("%s_grant%0d", tag, got), 64'(ch), 64'((got * step) % 3));
        if (got > 0) begin
          exp_rv = 3'b000;
          exp_rv[last_ch] = 1'b1;
          check($sformatf("%s_gap%0d", tag, got), 64'(cyc - last_cyc), 64'd2);
          check($sformatf("%s_resp%0d", tag, got), 64'(b_resp_valid), 64'(exp_rv));
          check($sformatf("%s_rdata%0d", tag, got), 64'(b_resp_rdata),
                64'(32'hB000_0000 | 32'(last_ch + 1)));
        end
        last_cyc = cyc;
        last_ch  = ch;
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    b_req_valid = '0;
    check($sformatf("%s_count", tag), 64'(got), 64'(n));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : main
    bit   found;
    int   lat;

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'hB000_0000 | 32'(i);
    end
    mem_a[8'h10] = 32'hDEAD_BEEF;
    mem_a[8'h20] = 32'hAABB_CCDD;

    //           ch we  addr     wmask  wdata          lat rdata
    vecs[0] = '{0, 0, 20'h00010, 4'h0, 32'h0000_0000, 3, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1, 20'h00020, 4'h5, 32'h1234_5678, 4, 32'h0000_0000};
    vecs[2] = '{0, 0, 20'h00020, 4'h0, 32'h0000_0000, 3, 32'hAA34_CC78};
    vecs[3] = '{1, 0, 20'h00020, 4'h0, 32'h0000_0000, 3, 32'hAA34_CC78};
    vecs[4] = '{0, 1, 20'h00030, 4'hF, 32'hCAFE_F00D, 4, 32'h0000_0000};
    vecs[5] = '{1, 0, 20'h00030, 4'h0, 32'h0000_0000, 3, 32'hCAFE_F00D};
    vecs[6] = '{0, 1, 20'h00010, 4'h0, 32'hFFFF_FFFF, 4, 32'h0000_0000};
    vecs[7] = '{1, 0, 20'h00010, 4'h0, 32'h0000_0000, 3, 32'hDEAD_BEEF};
    vecs[8] = '{0, 1, 20'h00030, 4'h8, 32'h1122_3344, 4, 32'h0000_0000};
    vecs[9] = '{0, 0, 20'h00030, 4'h0, 32'h0000_0000, 3, 32'h11FE_F00D};

    // Both A channels request a read during reset. Nothing may be accepted.
    a_req_valid = 2'b11;
    a_req_we    = 2'b00;
    a_req_addr  = {20'h00010, 20'h00010};
    a_req_wmask = '0;
    a_req_wdata = '0;
    b_req_valid = '0;
    b_req_we    = '0;
    b_req_addr  = {20'h00003, 20'h00002, 20'h00001};
    b_req_wmask = '0;
    b_req_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",      64'(a_req_ready), 64'd0);
    check("rst_a_pins",     64'({a_ram_ce_n, a_ram_oe_n, a_ram_we_n, a_ram_be_n}), 64'(7'b111_0000));
    check("rst_b_pins",     64'({b_ram_ce_n, b_ram_oe_n, b_ram_we_n, b_ram_be_n}), 64'(7'b111_0000));
    check("rst_resp_valid", 64'(a_resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(a_resp_rdata), 64'd0);

    // A request is accepted in the first cycle after reset, and ptr=0 selects ch0.
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("first_ready", 64'(a_req_ready), 64'(2'b01));
    @(posedge clk);
    #1;
    a_req_valid = '0;
    lat   = 1;
    found = 1'b0;
    while (!found && lat < 10) begin
      @(negedge clk);
      if (a_resp_valid != '0) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check("first_latency", 64'(lat), 64'd3);
    check("first_resp",    64'(a_resp_valid), 64'(2'b01));
    check("first_rdata",   64'(a_resp_rdata), 64'(32'hDEAD_BEEF));
    @(posedge clk);
    #1;

    // Table-driven single-channel transactions on instance A.
    for (int i = 0; i < NV; i++) a_txn(i, vecs[i]);

    // Reset while a ch0 write is in WR. The write is dropped, and the pointer
    // moved to 1 by this grant is cleared to 0 again.
    a_req_valid = 2'b01;
    a_req_we    = 2'b01;
    a_req_addr[0 +: AW]  = 20'h00040;
    a_req_wmask[0 +: BW] = 4'hF;
    a_req_wdata[0 +: DW] = 32'h5555_AAAA;
    found = 1'b0;
    lat   = 0;
    while (!found && lat < 20) begin
      @(negedge clk);
      found = a_req_ready[0];
      @(posedge clk);
      #1;
      lat++;
    end
    a_req_valid = '0;
    check("wrrst_accept", 64'(found), 64'd1);
    @(negedge clk);
    check("wrrst_in_wr", 64'({a_ram_ce_n, a_ram_we_n}), 64'(2'b00));
    #2;
    rst = 1'b1;
    #1;
    check("wrrst_pins",  64'({a_ram_ce_n, a_ram_oe_n, a_ram_we_n, a_ram_be_n}), 64'(7'b111_0000));
    check("wrrst_resp",  64'(a_resp_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("wrrst_no_resp%0d", i), 64'(a_resp_valid), 64'd0);
      check($sformatf("wrrst_idle%0d", i), 64'({a_ram_ce_n, a_ram_we_n}), 64'(2'b11));
    end
    @(posedge clk);
    #1;
    a_req_we    = 2'b00;
    a_req_addr  = {20'h00010, 20'h00010};
    a_req_valid = 2'b11;
    @(negedge clk);
    check("wrrst_ptr0", 64'(a_req_ready), 64'(2'b01));
    @(posedge clk);
    #1;
    a_req_valid = '0;
    repeat (5) @(posedge clk);
    #1;

    // Instance B: round-robin with all three channels requesting, then
    // back-to-back reads from ch0 alone.
    b_stream("rr",  3'b111, 6, 1);
    b_stream("b2b", 3'b001, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
